c2c_link_supervisor: RTL

Parametrised link-bring-up supervisor for the Aurora chip-to-chip master and slave designs. It sequences the Aurora `pma_init` and `reset` inputs, checks that all `NUM_LANES` lanes and the channel come up and stay stable, and retries with a bounded count. It drives the board status LEDs and sits between the `sysclk` domain and the Aurora core inside the C2C block designs.

---
 rtl/c2c_pkg.sv | 29 ++
 rtl/c2c_sync_bits.sv | 24 ++
 rtl/c2c_link_supervisor.sv | 138 +++++++++++++
 3 files changed

// File: rtl/c2c_pkg.sv
// Shared types and helpers for the Aurora chip-to-chip link supervisor.
package c2c_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PMA_INIT,
        ST_RST,
        ST_WAIT_UP,
        ST_STABLE,
        ST_UP,
        ST_FAILED
    } c2c_link_state_t;

    localparam int LED_HEARTBEAT = 0;
    localparam int LED_READY     = 1;
    localparam int LED_BUSY      = 2;
    localparam int LED_FAILED    = 3;

    // Width of the shared phase timer: wide enough for the longest phase, never wraps.
    function automatic int c2c_timer_width(input int timeout_cycles, input int stable_cycles,
                                           input int reset_cycles);
        int longest;
        longest = timeout_cycles;
        if (stable_cycles > longest) longest = stable_cycles;
        if (reset_cycles > longest) longest = reset_cycles;
        return $clog2(longest + 1);
    endfunction

endpackage

// File: rtl/c2c_sync_bits.sv
// Two-flop synchroniser for a bundle of independent asynchronous status bits.
module c2c_sync_bits #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // NOTE: non-blocking assignments here give the two-stage shift; blocking would collapse it to one flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/c2c_link_supervisor.sv
// Aurora link bring-up supervisor: sequences PMA/core resets, qualifies lane and
// channel status, retries with a bounded budget and drives the status LEDs.
module c2c_link_supervisor
    import c2c_pkg::*;
#(
    parameter int NUM_LANES      = 2,
    parameter int RESET_CYCLES   = 128,
    parameter int TIMEOUT_CYCLES = 50_000_000,
    parameter int STABLE_CYCLES  = 1024,
    parameter int MAX_RETRIES    = 7,
    parameter int BLINK_CYCLES   = 25_000_000
) (
    input  logic                               sysclk,
    input  logic                               sys_reset,
    input  logic                               enable,
    input  logic [NUM_LANES-1:0]               lane_up,
    input  logic                               channel_up,
    input  logic                               hard_err,
    output logic                               aurora_pma_init,
    output logic                               aurora_reset,
    output logic                               link_ready,
    output logic                               link_failed,
    output logic [$clog2(MAX_RETRIES+1)-1:0]   retry_count,
    output logic [3:0]                         led_out
);

    localparam int TW = c2c_timer_width(TIMEOUT_CYCLES, STABLE_CYCLES, RESET_CYCLES);
    localparam int RW = $clog2(MAX_RETRIES + 1);
    localparam int BW = $clog2(BLINK_CYCLES + 1);

    localparam logic [TW-1:0] RESET_LAST   = TW'(RESET_CYCLES - 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] STABLE_LAST  = TW'(STABLE_CYCLES - 1);
    localparam logic [RW-1:0] RETRY_MAX    = RW'(MAX_RETRIES);
    localparam logic [BW-1:0] BLINK_LAST   = BW'(BLINK_CYCLES - 1);

    logic [NUM_LANES+1:0] status_s;
    logic                 all_up;

    c2c_sync_bits #(
        .WIDTH (NUM_LANES + 2)
    ) u_sync (
        .clk (sysclk),
        .rst (sys_reset),
        .d   ({hard_err, channel_up, lane_up}),
        .q   (status_s)
    );

    assign all_up = (&status_s[NUM_LANES-1:0]) & status_s[NUM_LANES] & ~status_s[NUM_LANES+1];

    c2c_link_state_t state, state_n;
    logic [TW-1:0]   timer, timer_n;
    logic [RW-1:0]   retry_n;
    logic [BW-1:0]   blink_cnt, blink_cnt_n;
    logic            blink_n;
    logic            timer_inc;
    logic            fail_attempt;
    logic            busy_n;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_n      = state;
        retry_n      = retry_count;
        timer_inc    = 1'b0;
        fail_attempt = 1'b0;

        if (!enable) begin
            state_n = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:     state_n = ST_PMA_INIT;
                ST_PMA_INIT: if (timer == RESET_LAST) state_n = ST_RST; else timer_inc = 1'b1;
                ST_RST:      if (timer == RESET_LAST) state_n = ST_WAIT_UP; else timer_inc = 1'b1;
                ST_WAIT_UP: begin
                    if (all_up)                     state_n = ST_STABLE;
                    else if (timer == TIMEOUT_LAST) fail_attempt = 1'b1;
                    else                            timer_inc = 1'b1;
                end
                ST_STABLE: begin
                    if (!all_up) begin
                        state_n = ST_WAIT_UP;
                    end else if (timer == STABLE_LAST) begin
                        state_n = ST_UP;
                        retry_n = '0;
                    end else begin
                        timer_inc = 1'b1;
                    end
                end
                ST_UP:     if (!all_up) fail_attempt = 1'b1;
                ST_FAILED: state_n = ST_FAILED;
                default:   state_n = ST_IDLE;
            endcase
        end

        if (fail_attempt) begin
            retry_n = (retry_count == RETRY_MAX) ? RETRY_MAX : retry_count + RW'(1);
            state_n = (retry_n == RETRY_MAX) ? ST_FAILED : ST_PMA_INIT;
        end

        if (state_n == ST_IDLE) retry_n = '0;
    end

    // The timer restarts on every state change, including STABLE falling back to WAIT_UP.
    assign timer_n = (state_n != state) ? '0 : (timer_inc ? timer + TW'(1) : timer);

    assign blink_cnt_n = (blink_cnt == BLINK_LAST) ? '0 : blink_cnt + BW'(1);
    assign blink_n     = led_out[LED_HEARTBEAT] ^ (blink_cnt == BLINK_LAST);
    assign busy_n      = state_n inside {ST_PMA_INIT, ST_RST, ST_WAIT_UP, ST_STABLE};

    // Outputs are decoded from the next state so they move in the same cycle as the state register.
    always_ff @(posedge sysclk or posedge sys_reset) begin
        if (sys_reset) begin
            state           <= ST_IDLE;
            timer           <= '0;
            retry_count     <= '0;
            blink_cnt       <= '0;
            aurora_pma_init <= 1'b1;
            aurora_reset    <= 1'b1;
            link_ready      <= 1'b0;
            link_failed     <= 1'b0;
            led_out         <= '0;
        end else begin
            state           <= state_n;
            timer           <= timer_n;
            retry_count     <= retry_n;
            blink_cnt       <= blink_cnt_n;
            aurora_pma_init <= state_n inside {ST_IDLE, ST_PMA_INIT, ST_FAILED};
            aurora_reset    <= !(state_n inside {ST_WAIT_UP, ST_STABLE, ST_UP});
            link_ready      <= (state_n == ST_UP);
            link_failed     <= (state_n == ST_FAILED);
            led_out[LED_HEARTBEAT] <= blink_n;
            led_out[LED_READY]     <= (state_n == ST_UP);
            led_out[LED_BUSY]      <= blink_n & busy_n;
            led_out[LED_FAILED]    <= (state_n == ST_FAILED);
        end
    end

endmodule
